// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank register file: write-op encodings and address sizing.
package reg_bank_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_CLEAR = 2'b11
    } wr_op_e;

    // Address width never drops below one bit, even for a two-entry bank.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational next-value and wrap detection for a single reg_bank write.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0] old_val,
    input  wr_op_e           op,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] new_val_c,
    output logic             wrap_c
);

    always_comb begin
        new_val_c = old_val;
        wrap_c    = 1'b0;
        unique case (op)
            OP_LOAD:  new_val_c = wr_data;
            OP_INC: begin
                new_val_c = old_val + WIDTH'(1);
                wrap_c    = &old_val;
            end
            OP_DEC: begin
                new_val_c = old_val - WIDTH'(1);
                wrap_c    = ~|old_val;
            end
            OP_CLEAR: new_val_c = '0;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Flip-flop register bank with one read-modify-write port and two registered,
// write-through read ports; out-of-range addresses are flagged and ignored.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [OP_W-1:0]   wr_op,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              wrap,
    output logic              addr_err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             ra_in_range;
    logic             rb_in_range;
    logic             wr_accept;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_b;
    logic [WIDTH-1:0] alu_val;
    logic             alu_wrap;

    assign wr_in_range = ({1'b0, wr_addr}   < DEPTH_W);
    assign ra_in_range = ({1'b0, rd_addr_a} < DEPTH_W);
    assign rb_in_range = ({1'b0, rd_addr_b} < DEPTH_W);
    assign wr_accept   = wr_en && wr_in_range;

    // Entry select muxes; an address past the last entry yields zero.
    always_comb begin
        wr_old = '0;
        mem_a  = '0;
        mem_b  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr   == AW'(i)) wr_old = mem[i];
            if (rd_addr_a == AW'(i)) mem_a  = mem[i];
            if (rd_addr_b == AW'(i)) mem_b  = mem[i];
        end
    end

    reg_bank_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .old_val   (wr_old),
        .op        (wr_op_e'(wr_op)),
        .wr_data   (wr_data),
        .new_val_c (alu_val),
        .wrap_c    (alu_wrap)
    );

    // Storage, read registers with same-cycle write bypass, and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            wrap      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (wr_accept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_addr == AW'(i)) mem[i] <= alu_val;
                end
            end
            rd_data_a <= (wr_accept && rd_addr_a == wr_addr) ? alu_val : mem_a;
            rd_data_b <= (wr_accept && rd_addr_b == wr_addr) ? alu_val : mem_b;
            wrap      <= wr_accept && alu_wrap;
            addr_err  <= (wr_en && !wr_in_range) || !ra_in_range || !rb_in_range;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Randomized self-checking bench for reg_bank against a behavioural array model,
// plus directed sequences with literal expectations.
module tb_reg_bank;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AW    = 3;
    localparam int unsigned MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_op = 2'b00;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [AW-1:0]    rd_addr_a = '0;
    logic [AW-1:0]    rd_addr_b = '0;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             wrap;
    logic             addr_err;

    int checks = 0;
    int errors = 0;

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_op     (wr_op),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wrap      (wrap),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: entries as plain integers, reads observe the post-write state.
    int unsigned m [DEPTH];
    int unsigned exp_a, exp_b;
    logic        exp_wrap, exp_err;

    always @(posedge clk or posedge rst) begin
        int unsigned v;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m[i] = 0;
            exp_a = 0; exp_b = 0; exp_wrap = 1'b0; exp_err = 1'b0;
        end else begin
            exp_wrap = 1'b0;
            if (wr_en && wr_addr < DEPTH) begin
                v = m[wr_addr];
                case (wr_op)
                    2'd0: v = wr_data;
                    2'd1: begin v = (v + 1) % MOD;       exp_wrap = (v == 0);       end
                    2'd2: begin v = (v + MOD - 1) % MOD; exp_wrap = (v == MOD - 1); end
                    default: v = 0;
                endcase
                m[wr_addr] = v;
            end
            exp_a   = (rd_addr_a < DEPTH) ? m[rd_addr_a] : 0;
            exp_b   = (rd_addr_b < DEPTH) ? m[rd_addr_b] : 0;
            exp_err = (wr_en && wr_addr >= DEPTH) || rd_addr_a >= DEPTH || rd_addr_b >= DEPTH;
        end
    end

    always @(negedge clk) begin
        chk("model_rd_data_a", 32'(rd_data_a), exp_a);
        chk("model_rd_data_b", 32'(rd_data_b), exp_b);
        chk("model_wrap",      32'(wrap),      32'(exp_wrap));
        chk("model_addr_err",  32'(addr_err),  32'(exp_err));
    end

    // Apply one cycle of inputs, return at the negedge where its results are visible.
    task automatic cyc(input logic we, input logic [1:0] op, input logic [AW-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        wr_en = we; wr_op = op; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] wd;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rd_a", 32'(rd_data_a), 32'h0);
        chk("reset_flags", {30'h0, wrap, addr_err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 2'd0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
            chk("post_reset_rd_a", 32'(rd_data_a), 32'h0);
        end

        cyc(1'b1, 2'd0, 3'd3, 24'h00ABCD, 3'd0, 3'd0);
        cyc(1'b0, 2'd0, 3'd0, 24'h0, 3'd3, 3'd0);
        chk("load3_read", 32'(rd_data_a), 32'h00ABCD);

        cyc(1'b1, 2'd0, 3'd5, 24'hFFFFFF, 3'd5, 3'd5);
        cyc(1'b1, 2'd1, 3'd5, 24'h0, 3'd5, 3'd5);
        chk("inc_wrap_val",  32'(rd_data_a), 32'h0);
        chk("inc_wrap_flag", 32'(wrap),      32'h1);
        cyc(1'b0, 2'd0, 3'd0, 24'h0, 3'd5, 3'd5);
        chk("wrap_one_cycle", 32'(wrap), 32'h0);
        cyc(1'b1, 2'd2, 3'd5, 24'h0, 3'd5, 3'd0);
        chk("dec_wrap_val",  32'(rd_data_a), 32'hFFFFFF);
        chk("dec_wrap_flag", 32'(wrap),      32'h1);

        cyc(1'b1, 2'd0, 3'd2, 24'd7, 3'd0, 3'd0);
        cyc(1'b1, 2'd1, 3'd2, 24'h0, 3'd2, 3'd2);
        chk("bypass_a", 32'(rd_data_a), 32'd8);
        chk("bypass_b", 32'(rd_data_b), 32'd8);

        cyc(1'b1, 2'd0, 3'd7, 24'h123456, 3'd3, 3'd6);
        chk("oor_rd_b",  32'(rd_data_b), 32'h0);
        chk("oor_err",   32'(addr_err),  32'h1);
        chk("oor_keep3", 32'(rd_data_a), 32'h00ABCD);
        cyc(1'b0, 2'd0, 3'd0, 24'h0, 3'd0, 3'd0);
        chk("err_one_cycle", 32'(addr_err), 32'h0);

        cyc(1'b1, 2'd0, 3'd1, 24'd4, 3'd1, 3'd1);
        cyc(1'b1, 2'd1, 3'd1, 24'h0, 3'd1, 3'd1);
        chk("first_inc", 32'(rd_data_a), 32'd5);
        #2 rst = 1'b1;
        #1 chk("async_reset_rd_a", 32'(rd_data_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 2'd0, 3'd0, 24'h0, 3'd1, 3'd1);
        chk("after_reset_entry1", 32'(rd_data_a), 32'h0);
        chk("after_reset_wrap",   32'(wrap),      32'h0);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       wd = 24'hFFFFFF;
                1:       wd = 24'h0;
                default: wd = WIDTH'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                AW'($urandom_range(0, 7)), wd,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning data width of every entry.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries (2..256, power of two not required).
REQ-003 The block SHALL have localparam AW = max(1, clog2(DEPTH)), meaning address width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 The block SHALL have port wr_en, input, 1, meaning write-port request this cycle.
REQ-007 The block SHALL have port wr_op, input, 2, meaning write operation: 00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
REQ-008 The block SHALL have port wr_addr, input, AW, meaning target entry.
REQ-009 The block SHALL have port wr_data, input, WIDTH, meaning LOAD value; ignored for other ops.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, input, AW each, meaning read-port A/B entry selects.
REQ-011 The block SHALL have ports rd_data_a and rd_data_b, output, WIDTH each, meaning registered read results.
REQ-012 The block SHALL have port wrap, output, 1, meaning one-cycle pulse: last INC/DEC wrapped.
REQ-013 The block SHALL have port addr_err, output, 1, meaning one-cycle pulse: an out-of-range address was presented.

Function
REQ-014 On a clock edge with wr_en=1 and wr_addr<DEPTH, the entry SHALL take: LOAD wr_data; INC old+1 mod 2^WIDTH; DEC old-1 mod 2^WIDTH; CLEAR 0.
REQ-015 With wr_en=0, all entries SHALL hold their value.
REQ-016 wrap SHALL be 1 in the cycle after an accepted INC of all-ones (result 0) or DEC of 0 (result all-ones), else 0.
REQ-017 rd_data_a/b SHALL update every clock edge with the selected entry, giving one-cycle read latency.
REQ-018 When a read address equals an accepted write address in the same cycle, that read port SHALL return the newly written value (write-through bypass), including INC/DEC/CLEAR results.
REQ-019 Both read ports SHALL operate independently; both may select the same entry.
REQ-020 A write with wr_addr>=DEPTH SHALL be ignored (no entry changes, wrap stays 0).
REQ-021 A read with address>=DEPTH SHALL return 0 on that port.
REQ-022 addr_err SHALL be 1 in the cycle after any of: accepted-request wr_addr>=DEPTH, rd_addr_a>=DEPTH, rd_addr_b>=DEPTH; else 0.
REQ-023 Arithmetic SHALL be unsigned WIDTH-bit; no saturation.

Reset
REQ-024 While rst=1, all entries, rd_data_a, rd_data_b, wrap and addr_err SHALL be 0, asynchronously.
REQ-025 A write coinciding with the edge on which rst deasserts is not required to take effect; the first write guaranteed to take effect is on the next rising edge after rst is low.
REQ-026 Reset asserted mid-sequence SHALL discard any in-flight write and clear all pulses.

Structure
REQ-027 Op encodings (OP_LOAD, OP_INC, OP_DEC, OP_CLEAR) SHALL live in shared package reg_bank_pkg.
REQ-028 Next-value computation and wrap detection SHALL be a combinational sub-module reg_bank_alu (inputs: old value, op, wr_data; outputs: new value, wrap).
REQ-029 Storage SHALL be flip-flops, not inferred RAM, so that async reset is possible.

Verification
REQ-030 Reset, then read all entries -> rd_data_a=rd_data_b=0, wrap=0, addr_err=0.
REQ-031 LOAD entry 3 with 0x00ABCD, read A=3 next cycle -> rd_data_a=0x00ABCD one cycle after the read is presented.
REQ-032 LOAD entry 5 with 0xFFFFFF, then INC 5 -> entry 0, wrap=1 for exactly one cycle; DEC 5 -> 0xFFFFFF, wrap=1.
REQ-033 Same cycle: INC entry 2 (holding 7) with rd_addr_a=2, rd_addr_b=2 -> both read 8 next cycle.
REQ-034 DEPTH=6: write addr 7 and read B=6 -> no entry changes, rd_data_b=0, addr_err=1 for one cycle.
REQ-035 Assert rst between two back-to-back INCs on entry 1 (holding 4) -> entry 1 reads 0 after reset, wrap=0.
